// File: rtl/stream_dispatcher_pkg.sv
// Shared definitions for the stream dispatcher slice.
// Contents: default widths used by the interface and top, and the dispatcher FSM encoding.
package stream_dispatcher_pkg;

  localparam int unsigned STREAM_COUNT_DEF = 2;
  localparam int unsigned T_DATA_WIDTH_DEF = 8;
  localparam int unsigned T_ID_WIDTH_DEF   = 4;
  localparam int unsigned T_QOS_WIDTH_DEF  = 4;
  localparam int unsigned DROP_CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

endpackage

// File: rtl/stream_dispatcher_if.sv
// Bus bundle for the stream dispatcher: one merged input stream plus the fanned-out
// per-stream outputs and the dropped-packet count.
// Modports:
//   slave  - dispatcher side (consumes s_*, m_ready_i; drives s_ready_o, m_*, drop_cnt_o)
//   master - environment side (the mirror image)
interface stream_dispatcher_if
  import stream_dispatcher_pkg::*;
#(
  parameter int unsigned STREAM_COUNT = STREAM_COUNT_DEF,
  parameter int unsigned T_DATA_WIDTH = T_DATA_WIDTH_DEF,
  parameter int unsigned T_ID_WIDTH   = T_ID_WIDTH_DEF,
  parameter int unsigned T_QOS__WIDTH = T_QOS_WIDTH_DEF,
  parameter int unsigned DROP_CNT_W   = DROP_CNT_W_DEF
);

  logic [T_DATA_WIDTH-1:0] s_data_i;
  logic [T_ID_WIDTH-1:0]   s_id_i;
  logic [T_QOS__WIDTH-1:0] s_qos_i;
  logic                    s_last_i;
  logic                    s_valid_i;
  logic                    s_ready_o;

  logic [T_DATA_WIDTH-1:0] m_data_o [0:STREAM_COUNT-1];
  logic [T_QOS__WIDTH-1:0] m_qos_o  [0:STREAM_COUNT-1];
  logic [STREAM_COUNT-1:0] m_last_o;
  logic [STREAM_COUNT-1:0] m_valid_o;
  logic [STREAM_COUNT-1:0] m_ready_i;

  logic [DROP_CNT_W-1:0]   drop_cnt_o;

  modport slave (
    input  s_data_i, s_id_i, s_qos_i, s_last_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_qos_o, m_last_o, m_valid_o, drop_cnt_o
  );

  modport master (
    output s_data_i, s_id_i, s_qos_i, s_last_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_qos_o, m_last_o, m_valid_o, drop_cnt_o
  );

endinterface

// File: rtl/stream_dispatcher_reg_slice.sv
// One-deep valid/ready register slice for an opaque payload.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_in_valid / o_in_ready         upstream handshake (o_in_ready is combinational)
//   i_in_payload                    payload captured on upstream accept
//   o_out_valid / i_out_ready       downstream handshake
//   o_out_payload                   registered payload, held while not consumed
module stream_dispatcher_reg_slice #(
  parameter int unsigned PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [PAYLOAD_W-1:0] i_in_payload,
  output logic                 o_out_valid,
  output logic [PAYLOAD_W-1:0] o_out_payload,
  input  logic                 i_out_ready
);

  logic                 r_valid;
  logic [PAYLOAD_W-1:0] r_payload;

  // Empty, or draining this cycle: a new beat can replace the old one with no bubble.
  assign o_in_ready    = ~r_valid | i_out_ready;
  assign o_out_valid   = r_valid;
  assign o_out_payload = r_payload;

  // Load has priority over unload so a simultaneous load/unload keeps the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
    end else if (i_in_valid && o_in_ready) begin
      r_valid   <= 1'b1;
      r_payload <= i_in_payload;
    end else if (i_out_ready) begin
      r_valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_dispatcher.sv
// Routes packets of one merged valid/ready stream to STREAM_COUNT output streams,
// selected by the TID of each packet's first beat and locked until TLAST. QoS is
// captured on the first beat and travels with every beat. Packets whose TID is out of
// range are consumed without output and counted in a saturating drop counter.
// Ports:
//   clk   clock, rising edge
//   nrst  async active-low reset
//   bus   stream_dispatcher_if.slave: s_* input stream, m_* per-stream outputs,
//         drop_cnt_o dropped-packet count
module stream_dispatcher
  import stream_dispatcher_pkg::*;
#(
  parameter int unsigned STREAM_COUNT = STREAM_COUNT_DEF,
  parameter int unsigned T_DATA_WIDTH = T_DATA_WIDTH_DEF,
  parameter int unsigned T_ID_WIDTH   = T_ID_WIDTH_DEF,
  parameter int unsigned T_QOS__WIDTH = T_QOS_WIDTH_DEF,
  parameter int unsigned DROP_CNT_W   = DROP_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 nrst,
  stream_dispatcher_if.slave   bus
);

  localparam int unsigned PAYLOAD_W = T_DATA_WIDTH + 1 + T_QOS__WIDTH + T_ID_WIDTH;

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] ROUTE = ST_ROUTE;
  localparam logic [1:0] DROP  = ST_DROP;

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic [T_ID_WIDTH-1:0]   r_sel;
  logic [T_QOS__WIDTH-1:0] r_qos;
  logic [DROP_CNT_W-1:0]   r_drop_cnt;

  logic                    w_id_ok;
  logic                    w_s_ready;
  logic                    w_accept;
  logic                    w_drop_done;
  logic                    w_slice_in_valid;
  logic                    w_slice_in_ready;
  logic [T_ID_WIDTH-1:0]   w_route_idx;
  logic [T_QOS__WIDTH-1:0] w_route_qos;
  logic [PAYLOAD_W-1:0]    w_in_payload;
  logic [PAYLOAD_W-1:0]    w_out_payload;
  logic                    w_out_valid;
  logic                    w_out_ready;
  logic [T_DATA_WIDTH-1:0] w_out_data;
  logic                    w_out_last;
  logic [T_QOS__WIDTH-1:0] w_out_qos;
  logic [T_ID_WIDTH-1:0]   w_out_idx;

  logic [T_DATA_WIDTH-1:0] w_m_data  [0:STREAM_COUNT-1];
  logic [T_QOS__WIDTH-1:0] w_m_qos   [0:STREAM_COUNT-1];
  logic [STREAM_COUNT-1:0] w_m_last;
  logic [STREAM_COUNT-1:0] w_m_valid;

  // One extra bit so STREAM_COUNT == 2**T_ID_WIDTH does not wrap to zero.
  assign w_id_ok = ({1'b0, bus.s_id_i} < (T_ID_WIDTH + 1)'(STREAM_COUNT));

  // DROP sinks beats unconditionally; otherwise readiness follows the output slot.
  always_comb begin
    w_s_ready = 1'b0;
    if (nrst) begin
      w_s_ready = (r_state == DROP) ? 1'b1 : w_slice_in_ready;
    end
  end

  assign bus.s_ready_o = w_s_ready;
  assign w_accept      = bus.s_valid_i & w_s_ready;

  // Only routable beats enter the output slot.
  assign w_slice_in_valid = bus.s_valid_i & nrst &
                            ((r_state == ROUTE) | ((r_state == IDLE) & w_id_ok));

  // First beat carries its own id/qos; later beats use the locked route.
  assign w_route_idx  = (r_state == IDLE) ? bus.s_id_i  : r_sel;
  assign w_route_qos  = (r_state == IDLE) ? bus.s_qos_i : r_qos;
  assign w_in_payload = {bus.s_data_i, bus.s_last_i, w_route_qos, w_route_idx};

  // A drop completes on the last beat of an out-of-range packet, single-beat included.
  assign w_drop_done = w_accept & bus.s_last_i &
                       ((r_state == DROP) | ((r_state == IDLE) & ~w_id_ok));

  // FSM state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && !bus.s_last_i) begin
          w_state_nxt = w_id_ok ? ROUTE : DROP;
        end
      end
      ROUTE, DROP: begin
        if (w_accept && bus.s_last_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Route latch, captured on an accepted in-range first beat.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sel <= '0;
      r_qos <= '0;
    end else if ((r_state == IDLE) && w_accept && w_id_ok) begin
      r_sel <= bus.s_id_i;
      r_qos <= bus.s_qos_i;
    end
  end

  // Saturating dropped-packet counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_drop_cnt <= '0;
    end else if (w_drop_done && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end
  end

  assign bus.drop_cnt_o = r_drop_cnt;

  stream_dispatcher_reg_slice #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_slice (
    .clk           (clk),
    .rst_n         (nrst),
    .i_in_valid    (w_slice_in_valid),
    .o_in_ready    (w_slice_in_ready),
    .i_in_payload  (w_in_payload),
    .o_out_valid   (w_out_valid),
    .o_out_payload (w_out_payload),
    .i_out_ready   (w_out_ready)
  );

  assign {w_out_data, w_out_last, w_out_qos, w_out_idx} = w_out_payload;

  // Only the targeted stream's ready can drain the slot.
  always_comb begin
    w_out_ready = 1'b0;
    for (int k = 0; k < int'(STREAM_COUNT); k++) begin
      if (w_out_idx == T_ID_WIDTH'(k)) begin
        w_out_ready = bus.m_ready_i[k];
      end
    end
  end

  // Fan-out decode: only the targeted stream sees the slot contents.
  always_comb begin
    w_m_valid = '0;
    w_m_last  = '0;
    for (int k = 0; k < int'(STREAM_COUNT); k++) begin
      w_m_data[k] = '0;
      w_m_qos[k]  = '0;
      if (w_out_idx == T_ID_WIDTH'(k)) begin
        w_m_valid[k] = w_out_valid;
        w_m_last[k]  = w_out_last;
        w_m_data[k]  = w_out_data;
        w_m_qos[k]   = w_out_qos;
      end
    end
  end

  assign bus.m_valid_o = w_m_valid;
  assign bus.m_last_o  = w_m_last;
  assign bus.m_data_o  = w_m_data;
  assign bus.m_qos_o   = w_m_qos;

endmodule
